// File: rtl/input_reader_if.sv
// ---------------------------------------------------------------------------
// | input_reader_if                                                         |
// | Board-pin and core read-port bundle for the input_reader block.         |
// | Rev 1.0  initial release                                                |
// ---------------------------------------------------------------------------
`default_nettype none

interface input_reader_if #(
  parameter int N_SW  = 16,
  parameter int N_BTN = 5
);
  logic [N_SW-1:0]  sw;
  logic [N_BTN-1:0] btn;
  logic             rd_en;
  logic [1:0]       rd_addr;
  logic [31:0]      rd_data;
  logic             rd_valid;

  // master: board pins plus the core's read requester
  modport master (
    output sw, btn, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  sw, btn, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/input_reader.sv
// ---------------------------------------------------------------------------
// | input_reader                                                            |
// | Synchronises and debounces switches/buttons, keeps sticky press flags   |
// | and a press counter, and serves them over a one-cycle read port.        |
// | Optional macro RELEASE_EVT_EN adds sticky release flags at addr2[31:16].|
// | Rev 1.0  initial release                                                |
// ---------------------------------------------------------------------------
`default_nettype none

module input_reader #(
  parameter int N_SW     = 16,
  parameter int N_BTN    = 5,
  parameter int DEBOUNCE = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input_reader_if.slave bus
);

  localparam int                 c_N_IN    = N_SW + N_BTN;
  localparam int                 c_CNT_W   = $clog2(DEBOUNCE);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE - 1);

  localparam logic [1:0] c_ADDR_SW   = 2'd0;
  localparam logic [1:0] c_ADDR_BTN  = 2'd1;
  localparam logic [1:0] c_ADDR_EVT  = 2'd2;
  localparam logic [1:0] c_ADDR_PCNT = 2'd3;

  logic [c_N_IN-1:0] r_s1;
  logic [c_N_IN-1:0] r_s2;
  logic [c_N_IN-1:0] w_deb;
  logic [c_N_IN-1:0] w_accept;

  logic [N_SW-1:0]   w_deb_sw;
  logic [N_BTN-1:0]  w_deb_btn;
  logic [N_BTN-1:0]  w_s2_btn;
  logic [N_BTN-1:0]  w_accept_btn;
  logic [N_BTN-1:0]  w_rise;
  logic [31:0]       w_rise_cnt;

  logic [N_BTN-1:0]  r_evt;
  logic [31:0]       r_press_cnt;
  logic              w_rd_evt;
  logic [31:0]       w_evt_word;
  logic [31:0]       w_rd_mux;

  // Two-flop synchroniser; buttons sit above switches in the combined vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {bus.btn, bus.sw};
      r_s2 <= r_s1;
    end
  end

  for (genvar i = 0; i < c_N_IN; i++) begin : g_deb
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_deb;

    assign w_accept[i] = (r_s2[i] != r_deb) && (r_cnt == c_CNT_MAX);
    assign w_deb[i]    = r_deb;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else if (r_s2[i] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_deb <= r_s2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_deb_sw     = w_deb[N_SW-1:0];
  assign w_deb_btn    = w_deb[c_N_IN-1:N_SW];
  assign w_s2_btn     = r_s2[c_N_IN-1:N_SW];
  assign w_accept_btn = w_accept[c_N_IN-1:N_SW];

  // Edges are taken from the accept strobe so a flag lands on the same edge as deb
  assign w_rise = w_accept_btn & w_s2_btn;

  always_comb begin
    w_rise_cnt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_rise_cnt = w_rise_cnt + 32'(w_rise[i]);
    end
  end

  assign w_rd_evt = bus.rd_en && (bus.rd_addr == c_ADDR_EVT);

  // Clearing the whole register is safe: only bits returned by this read are set now
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt <= '0;
    end else begin
      r_evt <= (w_rd_evt ? '0 : r_evt) | w_rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_press_cnt <= '0;
    end else begin
      r_press_cnt <= r_press_cnt + w_rise_cnt;
    end
  end

`ifdef RELEASE_EVT_EN
  logic [N_BTN-1:0] w_fall;
  logic [N_BTN-1:0] r_rel;

  assign w_fall = w_accept_btn & ~w_s2_btn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rel <= '0;
    end else begin
      r_rel <= (w_rd_evt ? '0 : r_rel) | w_fall;
    end
  end

  assign w_evt_word = {16'(r_rel), 16'(r_evt)};
`else
  assign w_evt_word = {16'h0000, 16'(r_evt)};
`endif

  always_comb begin
    w_rd_mux = '0;
    case (bus.rd_addr)
      c_ADDR_SW:   w_rd_mux = 32'(w_deb_sw);
      c_ADDR_BTN:  w_rd_mux = 32'(w_deb_btn);
      c_ADDR_EVT:  w_rd_mux = w_evt_word;
      c_ADDR_PCNT: w_rd_mux = r_press_cnt;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.rd_data  <= bus.rd_en ? w_rd_mux : 32'h0;
    end
  end

endmodule

`default_nettype wire
